// File: rtl/midi_uart_rx.sv
// MIDI 31250-baud 8N1 receiver: 2-flop sync, mid-bit sampling, one-cycle byte/framing-error strobes, break wait.
// Latency HALF_BIT + 9*CLKS_PER_BIT from IDLE seeing start low (+2 with MIDI_RX_MAJORITY_EN); no backpressure.
module midi_uart_rx #(
  parameter int CLKS_PER_BIT = 1600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  logic sync1_q, sync1_d;
  logic rx_s_q, rx_s_d;
  logic rx_in;

  always_comb begin
    sync1_d = rx;
    rx_s_d  = sync1_q;
  end

  // Line idles high, so the synchroniser resets to 1 to avoid a false start.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= sync1_d;
      rx_s_q  <= rx_s_d;
    end
  end

`ifdef MIDI_RX_MAJORITY_EN
  logic hist1_q, hist1_d;
  logic hist2_q, hist2_d;
  logic rx_f_q, rx_f_d;

  always_comb begin
    hist1_d = rx_s_q;
    hist2_d = hist1_q;
    rx_f_d  = (rx_s_q & hist1_q) | (rx_s_q & hist2_q) | (hist1_q & hist2_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist1_q <= 1'b1;
      hist2_q <= 1'b1;
      rx_f_q  <= 1'b1;
    end else begin
      hist1_q <= hist1_d;
      hist2_q <= hist2_d;
      rx_f_q  <= rx_f_d;
    end
  end

  assign rx_in = rx_f_q;
`else
  assign rx_in = rx_s_q;
`endif

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!rx_in) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end

      S_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d     = '0;
          bit_idx_d = 3'd0;
          state_d   = rx_in ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d              = '0;
          shift_d[bit_idx_q] = rx_in;
          bit_idx_d          = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      // Leaving on the sample cycle leaves half a bit to catch a back-to-back start edge.
      S_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_in) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_BREAK: begin
        if (rx_in) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_midi_uart_rx.sv
// Self-checking bench for midi_uart_rx at CLKS_PER_BIT=16; received bytes are scoreboarded against a queue.
module tb_midi_uart_rx;

  localparam int CPB = 16;
`ifdef MIDI_RX_MAJORITY_EN
  localparam int LAT = 156;
`else
  localparam int LAT = 154;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  int checks   = 0;
  int errors   = 0;
  int cyc      = 0;
  int ferr_cnt = 0;
  logic prev_strobe = 1'b0;
  logic [7:0] exp_b;

  logic [7:0] exp_q[$];
  int         vld_cyc[$];
  int         start_cyc[$];

  midi_uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .data     (data),
    .valid    (valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: strobe isolation and byte scoreboard.
  always @(negedge clk) begin
    if (valid || frame_err) begin
      checks++;
      if ((valid && frame_err) || prev_strobe) begin
        errors++;
        $display("FAIL strobe_isolation: valid=%b frame_err=%b prev_strobe=%b, required single isolated strobe",
                 valid, frame_err, prev_strobe);
      end
    end
    prev_strobe = valid || frame_err;
    if (frame_err) ferr_cnt++;
    if (valid) begin
      vld_cyc.push_back(cyc);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: data=%02h, required no strobe", data);
      end else begin
        exp_b = exp_q.pop_front();
        if (data !== exp_b) begin
          errors++;
          $display("FAIL rx_data: got %02h, required %02h", data, exp_b);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    rx  = 1'b1;
    tick(n);
    rst = 1'b0;
    exp_q.delete();
    vld_cyc.delete();
    start_cyc.delete();
    ferr_cnt = 0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input bit push);
    if (push) exp_q.push_back(b);
    start_cyc.push_back(cyc);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = stop;
    tick(CPB);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rx = ~rx;
      tick(1);
    end
    rst = 1'b0;
    rx  = 1'b1;
    checks++; if (data !== 8'h00)    begin errors++; $display("FAIL reset_data: got %02h, required 00", data); end
    checks++; if (valid !== 1'b0)    begin errors++; $display("FAIL reset_valid: got %b, required 0", valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b, required 0", frame_err); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
    tick(5);
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_idle_busy: got %b, required 0", busy); end
  endtask

  task automatic test_back_to_back;
    int lat;
    do_reset(2);
    tick(3);
    send_frame(8'h90, 1'b1, 1'b1);
    send_frame(8'h3C, 1'b1, 1'b1);
    send_frame(8'h7F, 1'b1, 1'b1);
    tick(20);
    checks++;
    if (vld_cyc.size() != 3) begin
      errors++;
      $display("FAIL b2b_count: got %0d valid pulses, required 3", vld_cyc.size());
    end else begin
      lat = vld_cyc[0] - (start_cyc[0] + 1);
      checks++; if (lat != LAT) begin errors++; $display("FAIL b2b_latency: got %0d, required %0d", lat, LAT); end
      checks++; if (vld_cyc[1] - vld_cyc[0] != 160) begin errors++; $display("FAIL b2b_spacing1: got %0d, required 160", vld_cyc[1] - vld_cyc[0]); end
      checks++; if (vld_cyc[2] - vld_cyc[1] != 160) begin errors++; $display("FAIL b2b_spacing2: got %0d, required 160", vld_cyc[2] - vld_cyc[1]); end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_pending: %0d bytes not received, required 0", exp_q.size()); end
    checks++; if (data !== 8'h7F) begin errors++; $display("FAIL b2b_hold: got %02h, required 7F", data); end
  endtask

  task automatic test_glitch;
    logic saw_busy;
    do_reset(2);
    tick(3);
    saw_busy = 1'b0;
    rx = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      if (busy) saw_busy = 1'b1;
    end
    rx = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (busy) saw_busy = 1'b1;
    end
    checks++; if (saw_busy !== 1'b1) begin errors++; $display("FAIL glitch_start: busy never rose, required 1"); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_abort: busy=%b, required 0", busy); end
    checks++; if (vld_cyc.size() != 0 || ferr_cnt != 0) begin
      errors++; $display("FAIL glitch_strobe: valid=%0d frame_err=%0d, required 0 and 0", vld_cyc.size(), ferr_cnt);
    end
  endtask

  task automatic test_frame_err;
    do_reset(2);
    tick(3);
    send_frame(8'h55, 1'b0, 1'b0);
    tick(40);
    rx = 1'b1;
    tick(20);
    checks++; if (ferr_cnt != 1) begin errors++; $display("FAIL ferr_count: got %0d, required 1", ferr_cnt); end
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL ferr_data: got %02h, required 00", data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ferr_break_exit: busy=%b, required 0", busy); end
    send_frame(8'hF8, 1'b1, 1'b1);
    tick(20);
    checks++; if (vld_cyc.size() != 1) begin errors++; $display("FAIL ferr_recover_count: got %0d, required 1", vld_cyc.size()); end
    checks++; if (data !== 8'hF8) begin errors++; $display("FAIL ferr_recover_data: got %02h, required F8", data); end
  endtask

  task automatic test_reset_mid;
    logic [7:0] b;
    b = 8'hAA;
    do_reset(2);
    tick(3);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 3; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = b[3];
    tick(CPB / 2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    rx  = 1'b1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b, required 0", busy); end
    tick(200);
    checks++; if (vld_cyc.size() != 0 || ferr_cnt != 0) begin
      errors++; $display("FAIL midrst_strobe: valid=%0d frame_err=%0d, required 0 and 0", vld_cyc.size(), ferr_cnt);
    end
    send_frame(8'hAA, 1'b1, 1'b1);
    tick(20);
    checks++; if (data !== 8'hAA || exp_q.size() != 0) begin
      errors++; $display("FAIL midrst_next: data=%02h pending=%0d, required AA and 0", data, exp_q.size());
    end
  endtask

`ifdef MIDI_RX_MAJORITY_EN
  task automatic test_majority;
    logic saw_busy;
    int lat;
    do_reset(2);
    tick(3);
    saw_busy = 1'b0;
    rx = 1'b0;
    tick(1);
    rx = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (busy) saw_busy = 1'b1;
    end
    checks++; if (saw_busy !== 1'b0) begin errors++; $display("FAIL maj_glitch: busy rose, required 0"); end
    send_frame(8'h90, 1'b1, 1'b1);
    tick(20);
    checks++;
    if (vld_cyc.size() != 1) begin
      errors++; $display("FAIL maj_count: got %0d, required 1", vld_cyc.size());
    end else begin
      lat = vld_cyc[0] - (start_cyc[0] + 1);
      checks++; if (lat != 156) begin errors++; $display("FAIL maj_latency: got %0d, required 156", lat); end
    end
  endtask
`endif

  initial begin
    test_reset;
    test_back_to_back;
    test_glitch;
    test_frame_err;
    test_reset_mid;
`ifdef MIDI_RX_MAJORITY_EN
    test_majority;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
